axi_addr_chan_responder: RTL and testbench

//  Subordinate (responder) end of the AXI AW and AR address channels, facing an

---
 rtl/axi_addr_chan_responder_if.sv | 30 +++
 rtl/axi_addr_chan_responder.sv | 173 +++++++++++++++++
 tb/tb_axi_addr_chan_responder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_addr_chan_responder_if.sv
// AXI AW/AR address-channel bundle between an upstream manager and
// the address-channel responder; master drives VALID/ADDR, slave READY.
interface axi_addr_chan_responder_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
    logic                  S_AXI_AWVALID;
    logic                  S_AXI_AWREADY;
    logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
    logic                  S_AXI_ARVALID;
    logic                  S_AXI_ARREADY;

    modport master (
        output S_AXI_AWADDR,
        output S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_ARADDR,
        output S_AXI_ARVALID,
        input  S_AXI_ARREADY
    );

    modport slave (
        input  S_AXI_AWADDR,
        input  S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_ARADDR,
        input  S_AXI_ARVALID,
        output S_AXI_ARREADY
    );
endinterface

// File: rtl/axi_addr_chan_responder.sv
// AXI AW/AR responder: per-channel FIFOs merged round-robin into one
// registered command stream. Optional AXI_ADDR_RESP_ALIGN_CHECK_EN.
module axi_addr_chan_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int ALIGN_LSB  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axi_addr_chan_responder_if.slave s_axi,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic                  cmd_write,
    output logic                  cmd_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    addr_t         aw_mem_q [FIFO_DEPTH];
    addr_t         aw_mem_d [FIFO_DEPTH];
    logic [PW-1:0] aw_wr_q, aw_wr_d;
    logic [PW-1:0] aw_rd_q, aw_rd_d;
    logic [CW-1:0] aw_cnt_q, aw_cnt_d;
    logic          aw_ready_q, aw_ready_d;

    addr_t         ar_mem_q [FIFO_DEPTH];
    addr_t         ar_mem_d [FIFO_DEPTH];
    logic [PW-1:0] ar_wr_q, ar_wr_d;
    logic [PW-1:0] ar_rd_q, ar_rd_d;
    logic [CW-1:0] ar_cnt_q, ar_cnt_d;
    logic          ar_ready_q, ar_ready_d;

    logic          cmd_valid_q, cmd_valid_d;
    addr_t         cmd_addr_q, cmd_addr_d;
    logic          cmd_write_q, cmd_write_d;
    // 1 = write channel won the last grant; reset to read so write wins first
    logic          last_w_q, last_w_d;

    logic aw_push, ar_push;
    logic aw_ne, ar_ne;
    logic load;
    logic grant_w, grant_r;

    assign aw_push = s_axi.S_AXI_AWVALID && aw_ready_q;
    assign ar_push = s_axi.S_AXI_ARVALID && ar_ready_q;
    assign aw_ne   = (aw_cnt_q != '0);
    assign ar_ne   = (ar_cnt_q != '0);
    assign load    = !cmd_valid_q || cmd_ready;
    assign grant_w = load && aw_ne && (!ar_ne || !last_w_q);
    assign grant_r = load && ar_ne && (!aw_ne || last_w_q);

    // Write-address FIFO: push on handshake, pop on grant, READY from next count
    always_comb begin
        aw_mem_d = aw_mem_q;
        aw_wr_d  = aw_wr_q;
        aw_rd_d  = aw_rd_q;
        if (aw_push) begin
            aw_mem_d[aw_wr_q] = s_axi.S_AXI_AWADDR;
            aw_wr_d = aw_wr_q + PW'(1);
        end
        if (grant_w) begin
            aw_rd_d = aw_rd_q + PW'(1);
        end
        aw_cnt_d   = aw_cnt_q + CW'(aw_push) - CW'(grant_w);
        aw_ready_d = (aw_cnt_d < CW'(FIFO_DEPTH));
    end

    // Read-address FIFO: same structure as the write side
    always_comb begin
        ar_mem_d = ar_mem_q;
        ar_wr_d  = ar_wr_q;
        ar_rd_d  = ar_rd_q;
        if (ar_push) begin
            ar_mem_d[ar_wr_q] = s_axi.S_AXI_ARADDR;
            ar_wr_d = ar_wr_q + PW'(1);
        end
        if (grant_r) begin
            ar_rd_d = ar_rd_q + PW'(1);
        end
        ar_cnt_d   = ar_cnt_q + CW'(ar_push) - CW'(grant_r);
        ar_ready_d = (ar_cnt_d < CW'(FIFO_DEPTH));
    end

    // Output register: reload from the granted FIFO head whenever it is free
    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_write_d = cmd_write_q;
        last_w_d    = last_w_q;
        if (load) begin
            cmd_valid_d = grant_w || grant_r;
            if (grant_w) begin
                cmd_addr_d  = aw_mem_q[aw_rd_q];
                cmd_write_d = 1'b1;
                last_w_d    = 1'b1;
            end else if (grant_r) begin
                cmd_addr_d  = ar_mem_q[ar_rd_q];
                cmd_write_d = 1'b0;
                last_w_d    = 1'b0;
            end
        end
    end

    // State registers; reset discards every queued address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_mem_q    <= '{default: '0};
            aw_wr_q     <= '0;
            aw_rd_q     <= '0;
            aw_cnt_q    <= '0;
            aw_ready_q  <= 1'b0;
            ar_mem_q    <= '{default: '0};
            ar_wr_q     <= '0;
            ar_rd_q     <= '0;
            ar_cnt_q    <= '0;
            ar_ready_q  <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_write_q <= 1'b0;
            last_w_q    <= 1'b0;
        end else begin
            aw_mem_q    <= aw_mem_d;
            aw_wr_q     <= aw_wr_d;
            aw_rd_q     <= aw_rd_d;
            aw_cnt_q    <= aw_cnt_d;
            aw_ready_q  <= aw_ready_d;
            ar_mem_q    <= ar_mem_d;
            ar_wr_q     <= ar_wr_d;
            ar_rd_q     <= ar_rd_d;
            ar_cnt_q    <= ar_cnt_d;
            ar_ready_q  <= ar_ready_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_write_q <= cmd_write_d;
            last_w_q    <= last_w_d;
        end
    end

`ifdef AXI_ADDR_RESP_ALIGN_CHECK_EN
    localparam addr_t ALIGN_MASK =
        addr_t'((64'd1 << ALIGN_LSB) - 64'd1);

    logic cmd_err_q, cmd_err_d;

    // Flag misaligned addresses; the command itself is still forwarded
    always_comb begin
        cmd_err_d = |(cmd_addr_d & ALIGN_MASK);
    end

    // Error flag travels with the command register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_err_q <= 1'b0;
        end else begin
            cmd_err_q <= cmd_err_d;
        end
    end

    assign cmd_err = cmd_err_q;
`else
    assign cmd_err = 1'b0;
`endif

    assign s_axi.S_AXI_AWREADY = aw_ready_q;
    assign s_axi.S_AXI_ARREADY = ar_ready_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_write = cmd_write_q;

endmodule

// File: tb/tb_axi_addr_chan_responder.sv
// Directed bench for axi_addr_chan_responder: reset, single write,
// contention, backpressure, alignment flag and mid-stream reset.
module tb_axi_addr_chan_responder;
    localparam int AW = 32;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_write;
    logic          cmd_err;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef AXI_ADDR_RESP_ALIGN_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    axi_addr_chan_responder_if #(.ADDR_WIDTH(AW)) axi_if ();

    axi_addr_chan_responder #(
        .ADDR_WIDTH(AW),
        .FIFO_DEPTH(2),
        .ALIGN_LSB (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_axi    (axi_if.slave),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_write(cmd_write),
        .cmd_err  (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // advance one edge, then settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        axi_if.S_AXI_AWADDR  = '0;
        axi_if.S_AXI_AWVALID = 1'b0;
        axi_if.S_AXI_ARADDR  = '0;
        axi_if.S_AXI_ARVALID = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_ready = 1'b0;
        idle_inputs();

        // 1 reset state
        tick();
        check("rst_valid", cmd_valid, 0);
        check("rst_addr", cmd_addr, 0);
        check("rst_write", cmd_write, 0);
        check("rst_err", cmd_err, 0);
        check("rst_awready", axi_if.S_AXI_AWREADY, 0);
        check("rst_arready", axi_if.S_AXI_ARREADY, 0);
        rst_n = 1'b1;
        #1;
        check("rel_awready_pre", axi_if.S_AXI_AWREADY, 0);
        tick();
        check("rel_awready", axi_if.S_AXI_AWREADY, 1);
        check("rel_arready", axi_if.S_AXI_ARREADY, 1);

        // 2 single write
        cmd_ready = 1'b1;
        axi_if.S_AXI_AWADDR  = 32'h1000;
        axi_if.S_AXI_AWVALID = 1'b1;
        tick();
        idle_inputs();
        check("w1_lat_valid", cmd_valid, 0);
        tick();
        check("w1_valid", cmd_valid, 1);
        check("w1_addr", cmd_addr, 32'h1000);
        check("w1_write", cmd_write, 1);
        tick();
        check("w1_drop", cmd_valid, 0);

        // 3 contention, fresh arbiter state
        do_reset();
        cmd_ready = 1'b1;
        axi_if.S_AXI_AWADDR  = 32'hA0;
        axi_if.S_AXI_AWVALID = 1'b1;
        axi_if.S_AXI_ARADDR  = 32'hB0;
        axi_if.S_AXI_ARVALID = 1'b1;
        tick();
        axi_if.S_AXI_AWADDR  = 32'hA4;
        axi_if.S_AXI_ARADDR  = 32'hB4;
        tick();
        idle_inputs();
        check("rr0_addr", cmd_addr, 32'hA0);
        check("rr0_w", {cmd_valid, cmd_write}, 2'b11);
        tick();
        check("rr1_addr", cmd_addr, 32'hB0);
        check("rr1_w", {cmd_valid, cmd_write}, 2'b10);
        tick();
        check("rr2_addr", cmd_addr, 32'hA4);
        check("rr2_w", {cmd_valid, cmd_write}, 2'b11);
        tick();
        check("rr3_addr", cmd_addr, 32'hB4);
        check("rr3_w", {cmd_valid, cmd_write}, 2'b10);
        tick();
        check("rr_done", cmd_valid, 0);

        // 4 backpressure: 3 of 4 writes fit
        cmd_ready = 1'b0;
        axi_if.S_AXI_AWVALID = 1'b1;
        axi_if.S_AXI_AWADDR  = 32'h200;
        tick();
        axi_if.S_AXI_AWADDR  = 32'h204;
        tick();
        check("bp_awready_mid", axi_if.S_AXI_AWREADY, 1);
        axi_if.S_AXI_AWADDR  = 32'h208;
        tick();
        check("bp_awready_full", axi_if.S_AXI_AWREADY, 0);
        axi_if.S_AXI_AWADDR  = 32'h20C;
        tick();
        check("bp_awready_hold", axi_if.S_AXI_AWREADY, 0);
        check("bp_addr0", cmd_addr, 32'h200);
        tick();
        idle_inputs();
        check("bp_addr_stable", cmd_addr, 32'h200);
        check("bp_valid_stable", {cmd_valid, cmd_write}, 2'b11);
        cmd_ready = 1'b1;
        tick();
        check("bp_out1", cmd_addr, 32'h204);
        check("bp_awready_back", axi_if.S_AXI_AWREADY, 1);
        tick();
        check("bp_out2", cmd_addr, 32'h208);
        check("bp_out2_v", cmd_valid, 1);
        tick();
        check("bp_drained", cmd_valid, 0);

        // 5 alignment flag
        axi_if.S_AXI_AWADDR  = 32'h1002;
        axi_if.S_AXI_AWVALID = 1'b1;
        tick();
        idle_inputs();
        tick();
        check("al_mis_addr", cmd_addr, 32'h1002);
        check("al_mis_err", cmd_err, ERR_EN);
        axi_if.S_AXI_ARADDR  = 32'h1004;
        axi_if.S_AXI_ARVALID = 1'b1;
        tick();
        idle_inputs();
        tick();
        check("al_ok_addr", {cmd_valid, cmd_addr}, {1'b1, 32'h1004});
        check("al_ok_err", cmd_err, 0);
        tick();

        // 6 reset with queued entries
        cmd_ready = 1'b0;
        axi_if.S_AXI_AWADDR  = 32'h300;
        axi_if.S_AXI_AWVALID = 1'b1;
        axi_if.S_AXI_ARADDR  = 32'h400;
        axi_if.S_AXI_ARVALID = 1'b1;
        tick();
        idle_inputs();
        tick();
        check("mr_pre_valid", cmd_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mr_valid", cmd_valid, 0);
        check("mr_awready", axi_if.S_AXI_AWREADY, 0);
        tick();
        rst_n = 1'b1;
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mr_no_stale", cmd_valid, 0);
        end
        check("mr_awready_back", axi_if.S_AXI_AWREADY, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
